// File: rtl/avg_pool_sequencer_if.sv
// ---------------------------------------------------------------------------
// avg_pool_sequencer_if
// Groups the pixel-stream and average-write handshakes of avg_pool_sequencer.
//   i_valid   : pixel valid (upstream -> sequencer)
//   i_pixel   : 16 signed int8 channels, channel c at [8c+7:8c]
//   o_ready   : pixel accept (sequencer -> upstream)
//   o_wrValid : write beat valid (sequencer -> decoder)
//   i_wrReady : decoder accepts the beat
//   o_opcode  : average-write opcode 32..37, 0 when idle
//   o_avg     : three int8 result lanes, lane k at [8k+7:8k]
//   o_done    : one-cycle pulse after the last beat is accepted
// slave  = sequencer side, master = stream source / decoder side.
// ---------------------------------------------------------------------------
interface avg_pool_sequencer_if;
    logic         i_valid;
    logic [127:0] i_pixel;
    logic         o_ready;
    logic         o_wrValid;
    logic         i_wrReady;
    logic [5:0]   o_opcode;
    logic [23:0]  o_avg;
    logic         o_done;

    modport slave (
        input  i_valid, i_pixel, i_wrReady,
        output o_ready, o_wrValid, o_opcode, o_avg, o_done
    );

    modport master (
        output i_valid, i_pixel, i_wrReady,
        input  o_ready, o_wrValid, o_opcode, o_avg, o_done
    );
endinterface

// File: rtl/avg_pool_sequencer.sv
// ---------------------------------------------------------------------------
// avg_pool_sequencer
// Global-average-pooling sequencer for the MobileNet head. Accumulates
// PIXELS 16-channel int8 pixels, scales each channel sum by a fixed-point
// reciprocal (RECIP / 2^SHIFT, round-half-up, saturated to int8) and then
// issues average-write opcodes 32..37, three result lanes per beat.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : avg_pool_sequencer_if.slave (pixel stream in, write beats out)
// All handshake outputs are registers; there is no combinational path from
// i_valid or i_wrReady to any output.
// ---------------------------------------------------------------------------
module avg_pool_sequencer #(
    parameter int PIXELS = 49,
    parameter int ACC_W  = 16,
    parameter int RECIP  = 1337,
    parameter int SHIFT  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    avg_pool_sequencer_if.slave   bus
);

    localparam int CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    // ACC_W signed times a positive 17-bit multiplier, plus headroom.
    localparam int PROD_W = ACC_W + 18;

    localparam logic [CNT_W-1:0]         LAST_PIX = CNT_W'(PIXELS - 1);
    localparam longint                   ROUND_L  = longint'(1) << (SHIFT - 1);
    localparam logic signed [PROD_W-1:0] RECIP_S  = PROD_W'(RECIP);
    localparam logic signed [PROD_W-1:0] ROUND_S  = PROD_W'(ROUND_L);
    localparam logic signed [PROD_W-1:0] MAX8     = PROD_W'(127);
    localparam logic signed [PROD_W-1:0] MIN8     = -PROD_W'(128);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                  state_reg;
    logic signed [ACC_W-1:0] acc_reg [16];
    logic [CNT_W-1:0]        cnt_reg;
    logic [127:0]            avg_reg;
    logic [2:0]              beat_reg;
    logic                    ready_reg;
    logic                    wr_valid_reg;
    logic [5:0]              opcode_reg;
    logic [23:0]             avg_out_reg;
    logic                    done_reg;

    logic signed [ACC_W-1:0] pix_ext [16];
    logic [127:0]            avg_next;
    logic                    pix_accept;
    logic                    beat_accept;

    // ready_reg is only ever high in ACCUM, so this also gates by state.
    assign pix_accept  = bus.i_valid && ready_reg;
    assign beat_accept = wr_valid_reg && bus.i_wrReady;

    // Per-channel sign extension and scaled, rounded, saturated average.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_chan
            logic signed [PROD_W-1:0] prod;
            logic signed [PROD_W-1:0] rnd;

            assign pix_ext[gi] = ACC_W'($signed(bus.i_pixel[8*gi +: 8]));
            assign prod        = PROD_W'(acc_reg[gi]) * RECIP_S;
            assign rnd         = (prod + ROUND_S) >>> SHIFT;
            assign avg_next[8*gi +: 8] = (rnd > MAX8) ? 8'h7F :
                                         (rnd < MIN8) ? 8'h80 : rnd[7:0];
        end
    endgenerate

    // Lanes carried by beat b: three consecutive channels, except the last
    // beat, which carries channel 15 alone with zeroed upper lanes.
    function automatic logic [23:0] beat_lanes(input logic [127:0] v,
                                               input logic [2:0]   b);
        logic [23:0] w;
        if (b >= 3'd5) begin
            w = {16'd0, v[127:120]};
        end else begin
            w = v[int'(b) * 24 +: 24];
        end
        return w;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ACCUM;
            for (int c = 0; c < 16; c++) begin
                acc_reg[c] <= '0;
            end
            cnt_reg      <= '0;
            avg_reg      <= '0;
            beat_reg     <= '0;
            ready_reg    <= 1'b1;
            wr_valid_reg <= 1'b0;
            opcode_reg   <= '0;
            avg_out_reg  <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ACCUM: begin
                    if (pix_accept) begin
                        for (int c = 0; c < 16; c++) begin
                            acc_reg[c] <= acc_reg[c] + pix_ext[c];
                        end
                        if (cnt_reg == LAST_PIX) begin
                            state_reg <= CALC;
                            ready_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end

                CALC: begin
                    // Latch all averages and present the first beat directly
                    // from the freshly computed values.
                    avg_reg      <= avg_next;
                    state_reg    <= WRITE;
                    beat_reg     <= 3'd0;
                    wr_valid_reg <= 1'b1;
                    opcode_reg   <= 6'd32;
                    avg_out_reg  <= beat_lanes(avg_next, 3'd0);
                end

                WRITE: begin
                    if (beat_accept) begin
                        if (beat_reg == 3'd5) begin
                            state_reg    <= ACCUM;
                            for (int c = 0; c < 16; c++) begin
                                acc_reg[c] <= '0;
                            end
                            cnt_reg      <= '0;
                            beat_reg     <= 3'd0;
                            wr_valid_reg <= 1'b0;
                            opcode_reg   <= '0;
                            avg_out_reg  <= '0;
                            done_reg     <= 1'b1;
                            ready_reg    <= 1'b1;
                        end else begin
                            beat_reg    <= beat_reg + 3'd1;
                            opcode_reg  <= opcode_reg + 6'd1;
                            avg_out_reg <= beat_lanes(avg_reg, beat_reg + 3'd1);
                        end
                    end
                end

                default: begin
                    state_reg    <= ACCUM;
                    ready_reg    <= 1'b1;
                    wr_valid_reg <= 1'b0;
                    opcode_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.o_ready   = ready_reg;
    assign bus.o_wrValid = wr_valid_reg;
    assign bus.o_opcode  = opcode_reg;
    assign bus.o_avg     = avg_out_reg;
    assign bus.o_done    = done_reg;

endmodule

// File: doc/avg_pool_sequencer.md
# avg_pool_sequencer

Global-average-pooling sequencer for the MobileNet head. It accumulates a stream of 16-channel int8 pixels over one feature map and divides each channel sum by the pixel count using a fixed-point reciprocal. It then issues the six average-write opcodes 32..37 to the average write-select decoder, with three result lanes per beat. It sits directly upstream of that decoder and of the 16-channel average buffer it enables.

## Interface
- PIXELS, 49: pixels per feature map (≥1).
- ACC_W, 16: signed accumulator width per channel; must hold PIXELS×128.
- RECIP, 1337: unsigned reciprocal multiplier, equal to round(2^SHIFT / PIXELS).
- SHIFT, 16: right shift applied after the multiply.
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  pixel valid.
- i_pixel  in  128  16 signed int8 channels; channel c is at bits [8c+7:8c].
- o_ready  out  1  pixel accept; a pixel is accepted when i_valid && o_ready.
- o_wrValid  out  1  write beat valid.
- i_wrReady  in  1  downstream accepts the beat.
- o_opcode  out  6  average-write opcode 32..37; 0 when idle.
- o_avg  out  24  three int8 results; lane k is at bits [8k+7:8k].
- o_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: ACCUM, CALC, WRITE.
  - ACCUM → CALC on acceptance of pixel PIXELS.
  - CALC → WRITE after exactly 1 cycle.
  - WRITE → ACCUM on acceptance of the opcode-37 beat.
- ACCUM:
  - o_ready=1.
  - Each accepted pixel adds the sign-extended value of each channel into acc[c].
  - A 0..PIXELS-1 pixel counter increments per accepted pixel.
- CALC:
  - For every channel, avg[c] = sat8((acc[c]·RECIP + 2^(SHIFT-1)) >>> SHIFT).
  - The product is signed and full width (ACC_W+17 bits minimum).
  - The shift is arithmetic.
  - sat8 clamps to [-128, 127].
  - All 16 results are registered.
- WRITE, beat index b = 0..5:
  - o_opcode = 32+b.
  - For b ≤ 4, o_avg = {avg[3b+2], avg[3b+1], avg[3b]}.
  - For b = 5 (opcode 37), o_avg = {8'd0, 8'd0, avg[15]}.
- Beat handshake:
  - A beat advances only on o_wrValid && i_wrReady.
  - While i_wrReady=0, o_opcode and o_avg are held stable.
- On acceptance of the opcode-37 beat:
  - acc[*] and the pixel counter clear.
  - o_done=1 on the next cycle.
  - The next map may begin immediately.
- Outside ACCUM, o_ready=0 and i_valid/i_pixel are ignored.
- Outside WRITE, o_wrValid=0 and o_opcode=0, which the decoder maps to no write enables.

## Timing
- Reset, in the cycle after i_rst is sampled high:
  - state=ACCUM.
  - acc[*]=0, counter=0, avg[*]=0.
  - o_wrValid=0, o_opcode=0, o_avg=0, o_done=0.
  - o_ready=1.
- i_rst has priority over every other event, including mid-accumulation and mid-WRITE: a partial map is discarded and no further beats are issued.
- o_ready, o_wrValid, o_opcode and o_avg are registered or decoded from registered state only; there are no combinational paths from i_valid or i_wrReady.
- Latency: last pixel accepted at edge t → CALC during cycle t+1 → first beat (opcode 32) valid from edge t+2.
- With i_wrReady held at 1, the six beats occupy consecutive cycles t+2..t+7, o_done pulses at t+8, and o_ready=1 from t+8.
- Throughput: one pixel per cycle in ACCUM, and one beat per cycle while i_wrReady=1.
- PIXELS=1: the first accepted pixel moves the block directly to CALC.
- i_wrReady asserted before the first beat has no effect.
- o_done and the opcode-37 beat never coincide.

## Test plan
- Default parameters, 49 pixels with every channel = 100, i_wrReady=1 → first beat at t+2; opcodes 32,33,34,35,36,37 on consecutive cycles; o_avg = 0x646464 for beats 0..4 and 0x000064 for beat 5; o_done pulses once.
- Channel c = c-8 for all 49 pixels → averages -8..7; opcode 34 carries o_avg = {8'd0, 8'hFF, 8'hFE}; opcode 37 carries 0x000007.
- Rounding and extremes:
  - all channels 127 → 127;
  - all channels -128 → -128;
  - one pixel of 1 among 48 zeros → 0.
- Saturation with RECIP=2000 and all channels 127 → every lane = 127 (0x7F).
- Backpressure: drop i_wrReady for 3 cycles during opcode 33 → opcode and data held; no beat skipped or duplicated; i_valid pulses during WRITE are not accepted.
- Assert i_rst mid-WRITE (after opcode 34), then stream a fresh map of all 5s → o_opcode=0 the cycle after reset; next sequence is 32..37 with o_avg = 0x050505, uncontaminated by prior sums.
